nobl_fifo_ctrl: RTL and testbench

Circular-buffer FIFO controller that turns the external NoBL/ZBT SRAM into a deep streaming FIFO. It sits directly upstream of the SRAM pipeline interface: it issues one address/write/enable command per cycle to that interface and consumes its delayed read-data return (data_in/data_in_valid). It arbitrates between an input stream (writes) and an output stream (reads). Read data lands in a small on-chip skid buffer, and issued reads are credit-limited so the buffer never overflows.

---
 rtl/nobl_pkg.sv | 19 +
 rtl/nobl_skid_fifo.sv | 77 +++++++
 rtl/nobl_fifo_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_nobl_fifo_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nobl_pkg.sv
// nobl_pkg: shared definitions for the NoBL/ZBT SRAM FIFO controller and the
// SRAM pipeline interface it drives.
//   state_e       arbitration state encoding (idle / write burst / read burst)
//   Def*          default geometry constants shared with the SRAM interface
package nobl_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWr   = 2'd1,
      StRd   = 2'd2
   } state_e;

   localparam int unsigned DefWidth  = 18;
   localparam int unsigned DefDepth  = 19;
   localparam int unsigned DefRdLat  = 4;
   localparam int unsigned DefSkidAw = 3;
   localparam int unsigned DefBurst  = 8;

endpackage

// File: rtl/nobl_skid_fifo.sv
// nobl_skid_fifo: small register-based synchronous FIFO that absorbs SRAM read
// returns ahead of the output stream.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i/data_i  write side; a push while full is dropped
//   pop_i          read side; ignored while empty
//   data_o         head word, valid when valid_o
//   full_o         all 2^SKID_AW entries used
//   count_o        number of words held (0..2^SKID_AW)
module nobl_skid_fifo #(
   parameter int unsigned WIDTH   = 18,
   parameter int unsigned SKID_AW = 3
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               push_i,
   input  logic [WIDTH-1:0]   data_i,
   input  logic               pop_i,
   output logic [WIDTH-1:0]   data_o,
   output logic               valid_o,
   output logic               full_o,
   output logic [SKID_AW:0]   count_o
);

   localparam int unsigned Depth = 1 << SKID_AW;

   logic [WIDTH-1:0]   mem_q [Depth];
   logic [SKID_AW-1:0] wptr_q, wptr_d;
   logic [SKID_AW-1:0] rptr_q, rptr_d;
   logic [SKID_AW:0]   count_q, count_d;
   logic               push_ok, pop_ok;

   always_comb begin
      // count only reaches 2^SKID_AW when full, so its MSB is the full flag
      full_o  = count_q[SKID_AW];
      valid_o = (count_q != '0);
      count_o = count_q;
      data_o  = mem_q[rptr_q];

      push_ok = push_i & ~count_q[SKID_AW];
      pop_ok  = pop_i & (count_q != '0);

      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_ok) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (pop_ok) begin
         rptr_d = rptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/nobl_fifo_ctrl.sv
// nobl_fifo_ctrl: circular-buffer FIFO controller using an external NoBL/ZBT
// SRAM as deep storage. Arbitrates one SRAM op per cycle between the input
// stream (writes) and the output stream (reads), with bounded bursts. Read
// returns land in a skid buffer; reads are credit-limited so it never overflows.
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_data/in_src_rdy/in_dst_rdy      write stream
//   out_data/out_src_rdy/out_dst_rdy   read stream (skid buffer head)
//   address/data_out/write/enable      combinational command to SRAM interface
//   data_in/data_in_valid              delayed read return from SRAM interface
//   occupied/full/empty                words stored in SRAM and not yet read
//   overflow_err                       sticky: return arrived with skid full
module nobl_fifo_ctrl
   import nobl_pkg::*;
#(
   parameter int unsigned WIDTH   = DefWidth,
   parameter int unsigned DEPTH   = DefDepth,
   parameter int unsigned RD_LAT  = DefRdLat,
   parameter int unsigned SKID_AW = DefSkidAw,
   parameter int unsigned BURST   = DefBurst
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_src_rdy,
   output logic             in_dst_rdy,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src_rdy,
   input  logic             out_dst_rdy,
   output logic [DEPTH-1:0] address,
   output logic [WIDTH-1:0] data_out,
   output logic             write,
   output logic             enable,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_in_valid,
   output logic [DEPTH:0]   occupied,
   output logic             full,
   output logic             empty,
   output logic             overflow_err
);

   localparam int unsigned InfW      = $clog2(RD_LAT + 1);
   localparam int unsigned BurstW    = (BURST > 1) ? $clog2(BURST) : 1;
   localparam int unsigned SkidDepth = 1 << SKID_AW;
   localparam logic [BurstW-1:0] BurstLast = BurstW'(BURST - 1);

   state_e            state_q, state_d;
   logic [BurstW-1:0] burst_q, burst_d, burst_inc;
   logic [DEPTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [DEPTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [DEPTH:0]    occupied_q, occupied_d;
   logic [InfW-1:0]   inflight_q, inflight_d;
   logic              overflow_q, overflow_d;

   logic              wr_ok, rd_ok, do_wr, do_rd, burst_last, ret_valid;
   logic [SKID_AW:0]  skid_count;
   logic              skid_full, skid_valid, skid_pop;
   logic [WIDTH-1:0]  skid_data;

   assign full         = occupied_q[DEPTH];
   assign empty        = (occupied_q == '0);
   assign occupied     = occupied_q;
   assign overflow_err = overflow_q;

   // rst_n gates the requests so no command leaves while reset is held,
   // even though the input handshakes may still be active.
   assign wr_ok = rst_n & in_src_rdy & ~full;
   assign rd_ok = rst_n & ~empty & ((32'(skid_count) + 32'(inflight_q)) < SkidDepth);

   assign burst_last = (burst_q == BurstLast);
   // Saturate so a long uncontended burst still yields on the first contention.
   assign burst_inc  = burst_last ? burst_q : burst_q + 1'b1;

   // Arbitration
   always_comb begin
      do_wr   = 1'b0;
      do_rd   = 1'b0;
      state_d = state_q;
      burst_d = burst_q;

      unique case (state_q)
         StIdle: begin
            if (wr_ok) begin
               do_wr = 1'b1;
            end else if (rd_ok) begin
               do_rd = 1'b1;
            end
         end
         StWr: begin
            if (wr_ok && !(rd_ok && burst_last)) begin
               do_wr = 1'b1;
            end else if (rd_ok) begin
               do_rd = 1'b1;
            end
         end
         StRd: begin
            if (rd_ok && !(wr_ok && burst_last)) begin
               do_rd = 1'b1;
            end else if (wr_ok) begin
               do_wr = 1'b1;
            end
         end
         default: ;
      endcase

      if (do_wr) begin
         state_d = StWr;
         burst_d = (state_q == StWr) ? burst_inc : '0;
      end else if (do_rd) begin
         state_d = StRd;
         burst_d = (state_q == StRd) ? burst_inc : '0;
      end else begin
         state_d = StIdle;
         burst_d = '0;
      end
   end

   // SRAM command and stream handshakes
   always_comb begin
      enable     = do_wr | do_rd;
      write      = do_wr;
      in_dst_rdy = do_wr;
      address    = do_wr ? wr_ptr_q : rd_ptr_q;
      data_out   = in_data;
   end

   // Pointers, occupancy and read credits
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occupied_d = occupied_q;
      inflight_d = inflight_q;
      // A return with nothing outstanding (e.g. stale after reset) is not counted.
      ret_valid  = data_in_valid & (inflight_q != '0);

      if (do_wr) begin
         wr_ptr_d   = wr_ptr_q + 1'b1;
         occupied_d = occupied_q + 1'b1;
      end else if (do_rd) begin
         rd_ptr_d   = rd_ptr_q + 1'b1;
         occupied_d = occupied_q - 1'b1;
      end

      unique case ({do_rd, ret_valid})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase

      overflow_d = overflow_q | (data_in_valid & skid_full);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         burst_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occupied_q <= '0;
         inflight_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         burst_q    <= burst_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occupied_q <= occupied_d;
         inflight_q <= inflight_d;
         overflow_q <= overflow_d;
      end
   end

   assign skid_pop    = skid_valid & out_dst_rdy;
   assign out_src_rdy = skid_valid;
   assign out_data    = skid_data;

   nobl_skid_fifo #(
      .WIDTH   (WIDTH),
      .SKID_AW (SKID_AW)
   ) u_skid (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (data_in_valid),
      .data_i  (data_in),
      .pop_i   (skid_pop),
      .data_o  (skid_data),
      .valid_o (skid_valid),
      .full_o  (skid_full),
      .count_o (skid_count)
   );

endmodule

// File: tb/tb_nobl_fifo_ctrl.sv
// tb_nobl_fifo_ctrl: drives nobl_fifo_ctrl (DEPTH=4 so full/wrap are reachable)
// against a behavioural SRAM with fixed read latency, and checks it against a
// queue-based FIFO reference kept in the bench.
module tb_nobl_fifo_ctrl;

   localparam int unsigned W     = 18;
   localparam int unsigned D     = 4;
   localparam int unsigned LAT   = 4;
   localparam int unsigned SAW   = 3;
   localparam int unsigned BURST = 8;
   localparam int unsigned CAP   = 1 << D;
   localparam int unsigned SKID  = 1 << SAW;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] in_data;
   logic         in_src_rdy;
   logic         in_dst_rdy;
   logic [W-1:0] out_data;
   logic         out_src_rdy;
   logic         out_dst_rdy;
   logic [D-1:0] address;
   logic [W-1:0] data_out;
   logic         write;
   logic         enable;
   logic [W-1:0] data_in;
   logic         data_in_valid;
   logic [D:0]   occupied;
   logic         full;
   logic         empty;
   logic         overflow_err;

   always #5 clk = ~clk;

   nobl_fifo_ctrl #(
      .WIDTH   (W),
      .DEPTH   (D),
      .RD_LAT  (LAT),
      .SKID_AW (SAW),
      .BURST   (BURST)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_data       (in_data),
      .in_src_rdy    (in_src_rdy),
      .in_dst_rdy    (in_dst_rdy),
      .out_data      (out_data),
      .out_src_rdy   (out_src_rdy),
      .out_dst_rdy   (out_dst_rdy),
      .address       (address),
      .data_out      (data_out),
      .write         (write),
      .enable        (enable),
      .data_in       (data_in),
      .data_in_valid (data_in_valid),
      .occupied      (occupied),
      .full          (full),
      .empty         (empty),
      .overflow_err  (overflow_err)
   );

   // Behavioural SRAM: registered command, data returned LAT cycles later.
   logic [W-1:0] sram [CAP];
   logic         pv [LAT];
   logic [W-1:0] pd [LAT];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) begin
            pv[i] <= 1'b0;
            pd[i] <= '0;
         end
      end else begin
         if (enable && write) sram[address] <= data_out;
         pv[0] <= enable && !write;
         pd[0] <= sram[address];
         for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
         end
      end
   end
   assign data_in_valid = pv[LAT-1];
   assign data_in       = pd[LAT-1];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference model: words accepted but not yet delivered, plus occupancy
   // and credit bookkeeping derived from the FIFO rules.
   logic [W-1:0] q [$];
   int occ_m = 0, wr_cnt = 0, rd_cnt = 0, inflight_m = 0, skid_m = 0;
   int wr_streak = 0, rd_streak = 0, n_pop = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         bit rd_poss, wr_poss, wop, rop;
         rd_poss = (occ_m > 0) && (skid_m + inflight_m < SKID);
         wr_poss = in_src_rdy && (occ_m < CAP);
         wop = enable && write;
         rop = enable && !write;
         chk("occupied", 32'(occupied), occ_m);
         chk("full", full, occ_m == CAP);
         chk("empty", empty, occ_m == 0);
         chk("credit_bound", skid_m + inflight_m <= SKID, 1);
         chk("work_conserving", enable, rd_poss || wr_poss);
         chk("in_dst_rdy", in_dst_rdy, wop);
         chk("out_src_rdy", out_src_rdy, skid_m > 0);
         chk("overflow_err", overflow_err, 0);
         if (wop) begin
            chk("wr_addr", 32'(address), wr_cnt % CAP);
            chk("wr_data", 32'(data_out), 32'(in_data));
            q.push_back(in_data);
            wr_cnt++;
            occ_m++;
            if (rd_poss) begin
               wr_streak++;
               chk("wr_burst_len", wr_streak <= BURST, 1);
            end
         end else begin
            wr_streak = 0;
         end
         if (rop) begin
            chk("rd_addr", 32'(address), rd_cnt % CAP);
            rd_cnt++;
            occ_m--;
            inflight_m++;
            if (wr_poss) begin
               rd_streak++;
               chk("rd_burst_len", rd_streak <= BURST, 1);
            end
         end else begin
            rd_streak = 0;
         end
         if (data_in_valid) begin
            if (inflight_m > 0) inflight_m--;
            skid_m++;
         end
         if (out_src_rdy && out_dst_rdy) begin
            chk("pop_nonempty", q.size() > 0, 1);
            if (q.size() > 0) chk("out_data", 32'(out_data), 32'(q.pop_front()));
            if (skid_m > 0) skid_m--;
            n_pop++;
         end
      end
   end

   // Offer one word until accepted; out_dst_rdy randomised at rdy_pct percent.
   task automatic send_one(input logic [W-1:0] d, input int rdy_pct);
      bit ok = 0;
      in_src_rdy = 1'b1;
      in_data    = d;
      for (int c = 0; c < 200 && !ok; c++) begin
         out_dst_rdy = ($urandom_range(99) < rdy_pct);
         @(negedge clk);
         ok = in_dst_rdy;
         @(posedge clk);
         #1;
      end
      chk("send_accepted", ok, 1);
   endtask

   task automatic drain();
      in_src_rdy  = 1'b0;
      out_dst_rdy = 1'b1;
      for (int c = 0; c < 400 && (q.size() != 0 || occ_m != 0); c++) begin
         @(posedge clk);
         #1;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("drain_queue", q.size(), 0);
      chk("drain_empty", empty, 1);
   endtask

   initial begin
      bit ok;
      int pop0;
      in_data     = '0;
      in_src_rdy  = 1'b0;
      out_dst_rdy = 1'b0;
      rst_n       = 1'b1;
      #1 rst_n    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_enable", enable, 0);
      chk("rst_write", write, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_occupied", 32'(occupied), 0);
      chk("rst_out_src_rdy", out_src_rdy, 0);
      chk("rst_in_dst_rdy", in_dst_rdy, 0);
      chk("rst_overflow", overflow_err, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_enable", enable, 0);

      // Ten writes with output stalled: reads stop once skid credits run out.
      for (int i = 1; i <= 10; i++) send_one(W'(i), 0);
      in_src_rdy = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("stall_occupied", 32'(occupied), 2);
      chk("stall_out_src_rdy", out_src_rdy, 1);
      chk("stall_enable", enable, 0);
      chk("stall_overflow", overflow_err, 0);

      // Fill SRAM to capacity, then free one skid slot and watch the wrap.
      for (int i = 11; i <= 24; i++) send_one(W'(i), 0);
      in_src_rdy = 1'b1;
      in_data    = W'(25);
      @(negedge clk);
      chk("full_flag", full, 1);
      chk("full_in_dst_rdy", in_dst_rdy, 0);
      chk("full_enable", enable, 0);
      @(posedge clk);
      #1 out_dst_rdy = 1'b1;
      @(posedge clk);
      #1 out_dst_rdy = 1'b0;
      ok = 0;
      for (int c = 0; c < 10 && !ok; c++) begin
         @(negedge clk);
         ok = in_dst_rdy;
      end
      chk("refill_accepted", ok, 1);
      chk("refill_addr", 32'(address), 8);
      @(posedge clk);
      #1;
      drain();

      // Continuous stream, both sides always ready.
      for (int i = 0; i < 1000; i++) send_one(W'($urandom), 100);
      drain();

      // Random output stalls.
      for (int i = 0; i < 300; i++) send_one(W'($urandom), 70);
      drain();

      // Reset mid-stream with three reads outstanding.
      in_data     = 18'h2abcd;
      in_src_rdy  = 1'b1;
      out_dst_rdy = 1'b0;
      ok = 0;
      for (int c = 0; c < 60 && !ok; c++) begin
         @(posedge clk);
         ok = (inflight_m == 3);
      end
      chk("reach_inflight3", ok, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_enable", enable, 0);
      chk("arst_write", write, 0);
      chk("arst_occupied", 32'(occupied), 0);
      chk("arst_empty", empty, 1);
      chk("arst_out_src_rdy", out_src_rdy, 0);
      chk("arst_in_dst_rdy", in_dst_rdy, 0);
      q.delete();
      occ_m = 0; wr_cnt = 0; rd_cnt = 0; inflight_m = 0; skid_m = 0;
      wr_streak = 0; rd_streak = 0;
      in_src_rdy = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      pop0 = n_pop;
      for (int i = 0; i < 4; i++) send_one(W'($urandom), 100);
      drain();
      chk("post_reset_pops", n_pop - pop0, 4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
